// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED pattern generator. A shared prescaler produces a tick
// every PRESCALE clocks. Each channel has its own mode (OFF/ON/BLINK/BREATHE),
// a period in ticks and a tick counter. All LED outputs come straight from
// flops.
//
// Build option:
//   LED_BREATHE_EN  defined   -> BREATHE mode uses a free-running PWM counter
//                                 and a per-channel triangle-wave duty.
//                   undefined -> no PWM logic; mode 3 behaves as BLINK.
// ---------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int unsigned N_LED          = 2,
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned PWM_BITS       = 4,
  parameter logic [7:0]  DEFAULT_PERIOD = 8'd100
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_en,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_chan,
  input  logic [1:0]       i_wr_mode,
  input  logic [7:0]       i_wr_period,
  output logic [N_LED-1:0] o_LED,
  output logic             o_wr_ack,
  output logic             o_wr_err
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int unsigned     PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  // A zero period is stored as 1 so the wrap compare never underflows.
  localparam logic [7:0]      DEF_PER = (DEFAULT_PERIOD == 8'd0) ? 8'd1 : DEFAULT_PERIOD;

  logic [PS_W-1:0]  r_presc;
  mode_t            r_mode   [N_LED];
  logic [7:0]       r_period [N_LED];
  logic [7:0]       r_cnt    [N_LED];
  logic [N_LED-1:0] r_level;
  logic [N_LED-1:0] r_led;
  logic             r_ack;
  logic             r_err;

  logic             w_tick;
  logic [N_LED-1:0] w_wr_hit;
  logic             w_wr_any;
  logic [N_LED-1:0] w_step;
  logic [N_LED-1:0] w_pat;
  logic [7:0]       w_wr_period;
  mode_t            w_wr_mode;

`ifdef LED_BREATHE_EN
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_duty [N_LED];
  logic [N_LED-1:0]    r_up;
`else
  // PWM width has no effect when breathe support is left out.
  localparam int unsigned unused_pwm_bits = PWM_BITS;
`endif

  // Modes whose period wrap toggles the blink level.
  function automatic logic toggles_level(input mode_t m);
`ifdef LED_BREATHE_EN
    return (m == MODE_BLINK);
`else
    return (m == MODE_BLINK) || (m == MODE_BREATHE);
`endif
  endfunction

  // Tick, write decode and per-channel period-wrap detection.
  always_comb begin
    // NOTE: every signal gets a default before any conditional logic, so no
    // path leaves it unassigned and no latch is inferred.
    w_tick      = i_en && (r_presc == PS_LAST);
    w_wr_mode   = mode_t'(i_wr_mode);
    w_wr_period = (i_wr_period == 8'd0) ? 8'd1 : i_wr_period;
    w_wr_hit    = '0;
    w_step      = '0;
    for (int n = 0; n < N_LED; n++) begin
      w_wr_hit[n] = i_wr_en && (i_wr_chan == 4'(n));
      // A write on the same edge wins: that channel ignores the tick.
      w_step[n]   = w_tick && !w_wr_hit[n] && (r_cnt[n] >= r_period[n] - 8'd1);
    end
    w_wr_any = |w_wr_hit;
  end

  // Prescaler: counts 0..PRESCALE-1 while enabled, held at 0 otherwise.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop in the design
    // sees pre-edge values regardless of block ordering.
    if (!resetN) begin
      r_presc <= '0;
    end else if (!i_en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Write handshake: ack for an existing channel, error otherwise.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_wr_any;
      r_err <= i_wr_en && !w_wr_any;
    end
  end

  // Channel configuration and tick counters.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: these per-channel arrays are small flop banks, not RAM, so they
    // take the asynchronous reset like any other register.
    if (!resetN) begin
      for (int n = 0; n < N_LED; n++) begin
        r_mode[n]   <= MODE_BLINK;
        r_period[n] <= DEF_PER;
        r_cnt[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < N_LED; n++) begin
        if (w_wr_hit[n]) begin
          r_mode[n]   <= w_wr_mode;
          r_period[n] <= w_wr_period;
          r_cnt[n]    <= '0;
        end else if (w_tick) begin
          r_cnt[n]    <= w_step[n] ? 8'd0 : r_cnt[n] + 8'd1;
        end
      end
    end
  end

  // Blink level: toggles once per period in blinking modes.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_level <= '0;
    end else begin
      for (int n = 0; n < N_LED; n++) begin
        if (w_step[n] && toggles_level(r_mode[n])) begin
          r_level[n] <= ~r_level[n];
        end
      end
    end
  end

`ifdef LED_BREATHE_EN
  // Free-running PWM counter, advances on every enabled clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pwm <= '0;
    end else if (i_en) begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  // Triangle-wave duty: bounces between 0 and DUTY_MAX, ends not repeated.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_up <= '1;
      for (int n = 0; n < N_LED; n++) begin
        r_duty[n] <= '0;
      end
    end else begin
      for (int n = 0; n < N_LED; n++) begin
        if (w_step[n] && (r_mode[n] == MODE_BREATHE)) begin
          if (r_up[n]) begin
            if (r_duty[n] == DUTY_MAX) begin
              r_duty[n] <= r_duty[n] - 1'b1;
              r_up[n]   <= 1'b0;
            end else begin
              r_duty[n] <= r_duty[n] + 1'b1;
            end
          end else begin
            if (r_duty[n] == '0) begin
              r_duty[n] <= r_duty[n] + 1'b1;
              r_up[n]   <= 1'b1;
            end else begin
              r_duty[n] <= r_duty[n] - 1'b1;
            end
          end
        end
      end
    end
  end
`endif

  // Per-channel pattern from the current mode and state.
  always_comb begin
    w_pat = '0;
    for (int n = 0; n < N_LED; n++) begin
      unique case (r_mode[n])
        MODE_OFF:     w_pat[n] = 1'b0;
        MODE_ON:      w_pat[n] = 1'b1;
        MODE_BLINK:   w_pat[n] = r_level[n];
`ifdef LED_BREATHE_EN
        MODE_BREATHE: w_pat[n] = (r_pwm < r_duty[n]);
`else
        MODE_BREATHE: w_pat[n] = r_level[n];
`endif
      endcase
    end
  end

  // Registered LED drive, blanked while disabled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_led <= '0;
    end else begin
      r_led <= i_en ? w_pat : '0;
    end
  end

  assign o_LED    = r_led;
  assign o_wr_ack = r_ack;
  assign o_wr_err = r_err;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen (PRESCALE=4, N_LED=2, PWM_BITS=2,
// DEFAULT_PERIOD=2). A behavioural model derives each channel's output from
// "ticks elapsed since last write" and a triangle function; a compare process
// checks every cycle. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int NL      = 2;
  localparam int PS      = 4;
  localparam int PWM_B   = 2;
  localparam int DEF_PER = 2;
  localparam int PWM_MOD = 1 << PWM_B;
  localparam int DMAX    = PWM_MOD - 1;

`ifdef LED_BREATHE_EN
  localparam bit BREATHE = 1'b1;
`else
  localparam bit BREATHE = 1'b0;
`endif

  logic          clk;
  logic          resetN;
  logic          i_en;
  logic          i_wr_en;
  logic [3:0]    i_wr_chan;
  logic [1:0]    i_wr_mode;
  logic [7:0]    i_wr_period;
  logic [NL-1:0] o_LED;
  logic          o_wr_ack;
  logic          o_wr_err;

  led_pattern_gen #(
    .N_LED         (NL),
    .PRESCALE      (PS),
    .PWM_BITS      (PWM_B),
    .DEFAULT_PERIOD(8'(DEF_PER))
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .i_en       (i_en),
    .i_wr_en    (i_wr_en),
    .i_wr_chan  (i_wr_chan),
    .i_wr_mode  (i_wr_mode),
    .i_wr_period(i_wr_period),
    .o_LED      (o_LED),
    .o_wr_ack   (o_wr_ack),
    .o_wr_err   (o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int mode;
    int period;
    int ticks;       // ticks seen since the last write to this channel
    bit lvl_base;    // blink level at the last write
    int steps_base;  // duty steps taken before the last write
  } ch_t;

  ch_t           ch [NL];
  int            run_len;    // consecutive enabled edges since reset/disable
  int            pwm_edges;  // enabled edges since reset
  logic [NL-1:0] exp_led;
  logic          exp_ack;
  logic          exp_err;

  function automatic bit blinklike(input int m);
    return (m == 2) || (!BREATHE && m == 3);
  endfunction

  function automatic bit cur_level(input int n);
    if (blinklike(ch[n].mode)) return ch[n].lvl_base ^ bit'((ch[n].ticks / ch[n].period) % 2);
    return ch[n].lvl_base;
  endfunction

  function automatic int cur_steps(input int n);
    if (BREATHE && ch[n].mode == 3) return ch[n].steps_base + ch[n].ticks / ch[n].period;
    return ch[n].steps_base;
  endfunction

  function automatic int duty_of(input int s);
    int p;
    p = s % (2 * DMAX);
    return (p <= DMAX) ? p : 2 * DMAX - p;
  endfunction

  function automatic bit pattern(input int n);
    case (ch[n].mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cur_level(n);
      default: return BREATHE ? ((pwm_edges % PWM_MOD) < duty_of(cur_steps(n))) : cur_level(n);
    endcase
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int n = 0; n < NL; n++) ch[n] = '{2, DEF_PER, 0, 1'b0, 0};
      run_len   = 0;
      pwm_edges = 0;
      exp_led   = '0;
      exp_ack   = 1'b0;
      exp_err   = 1'b0;
    end else begin
      bit hit;
      bit tick;
      exp_led = '0;
      if (i_en) for (int n = 0; n < NL; n++) exp_led[n] = pattern(n);
      hit     = i_wr_en && (int'(i_wr_chan) < NL);
      exp_ack = hit;
      exp_err = i_wr_en && !hit;
      if (i_en) begin
        run_len++;
        pwm_edges++;
      end else begin
        run_len = 0;
      end
      tick = i_en && (run_len % PS == 0);
      for (int n = 0; n < NL; n++) begin
        if (hit && int'(i_wr_chan) == n) begin
          ch[n].lvl_base   = cur_level(n);
          ch[n].steps_base = cur_steps(n);
          ch[n].mode       = int'(i_wr_mode);
          ch[n].period     = (i_wr_period == 8'd0) ? 1 : int'(i_wr_period);
          ch[n].ticks      = 0;
        end else if (tick) begin
          ch[n].ticks++;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_led", 32'(o_LED), 32'(exp_led));
      check("model_ack", 32'(o_wr_ack), 32'(exp_ack));
      check("model_err", 32'(o_wr_err), 32'(exp_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int c, input int m, input int p);
    i_wr_en     = 1'b1;
    i_wr_chan   = 4'(c);
    i_wr_mode   = 2'(m);
    i_wr_period = 8'(p);
    @(negedge clk);
    i_wr_en     = 1'b0;
  endtask

  // Release reset at a negedge and pin the default blink timing.
  task automatic default_blink(input string tag);
    resetN = 1'b1;
    repeat (8) @(negedge clk);
    check({tag, "_e8"}, 32'(o_LED), 32'h0);
    @(negedge clk);
    check({tag, "_e9"}, 32'(o_LED), 32'h3);
    repeat (7) @(negedge clk);
    check({tag, "_e16"}, 32'(o_LED), 32'h3);
    @(negedge clk);
    check({tag, "_e17"}, 32'(o_LED), 32'h0);
  endtask

  initial begin
    int hi;
    resetN      = 1'b0;
    i_en        = 1'b1;
    i_wr_en     = 1'b0;
    i_wr_chan   = '0;
    i_wr_mode   = '0;
    i_wr_period = '0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(o_LED), 32'h0);
    check("reset_ack", 32'(o_wr_ack), 32'h0);
    check("reset_err", 32'(o_wr_err), 32'h0);
    cmp_on = 1'b1;

    default_blink("boot");

    // Channel 1 forced ON; channel 0 keeps blinking.
    i_wr_en = 1'b1; i_wr_chan = 4'd1; i_wr_mode = 2'd1; i_wr_period = 8'd2;
    @(negedge clk);                              // edge 18
    i_wr_en = 1'b0;
    check("on_ack", 32'(o_wr_ack), 32'h1);
    check("on_err", 32'(o_wr_err), 32'h0);
    check("on_led_e18", 32'(o_LED), 32'h0);
    @(negedge clk);                              // edge 19
    check("on_led_e19", 32'(o_LED), 32'h2);
    check("on_ack_drop", 32'(o_wr_ack), 32'h0);
    repeat (5) @(negedge clk);                   // edge 24
    check("on_led_e24", 32'(o_LED), 32'h2);
    @(negedge clk);                              // edge 25
    check("on_led_e25", 32'(o_LED), 32'h3);

    // Out-of-range channel: error pulse, nothing changes.
    i_wr_en = 1'b1; i_wr_chan = 4'd5; i_wr_mode = 2'd0; i_wr_period = 8'd0;
    @(negedge clk);                              // edge 26
    i_wr_en = 1'b0;
    check("bad_err", 32'(o_wr_err), 32'h1);
    check("bad_ack", 32'(o_wr_ack), 32'h0);
    check("bad_led", 32'(o_LED), 32'h3);
    @(negedge clk);                              // edge 27
    check("bad_err_drop", 32'(o_wr_err), 32'h0);

    // Mode 3, period 1 on channel 0; count high cycles over 6 tick windows.
    wr(0, 3, 1);                                 // edge 28
    repeat (4) @(negedge clk);                   // edge 32 (tick)
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      hi += int'(o_LED[0]);
    end
    check("breathe_hi_count", 32'(hi), BREATHE ? 32'd9 : 32'd12);

    // Write hammering across tick edges (write beats tick for that channel).
    for (int i = 0; i < 8; i++) wr(i % 2, 2 + (i % 2), 1 + (i % 3));

    // Randomized traffic with occasional enable drops.
    for (int c = 0; c < 400; c++) begin
      i_wr_en     = ($urandom_range(0, 5) == 0);
      i_wr_chan   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      i_wr_mode   = 2'($urandom_range(0, 3));
      i_wr_period = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 24) == 0) i_en = ~i_en;
      @(negedge clk);
    end
    i_wr_en = 1'b0;
    i_en    = 1'b1;

    // Disable for 20 clocks during blink; write still acknowledged.
    wr(0, 2, 2);
    wr(1, 2, 3);
    repeat (10) @(negedge clk);
    i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        i_wr_en = 1'b1; i_wr_chan = 4'd1; i_wr_mode = 2'd2; i_wr_period = 8'd1;
      end
      @(negedge clk);
      i_wr_en = 1'b0;
      check("en_off_led", 32'(o_LED), 32'h0);
      if (i == 5) check("en_off_ack", 32'(o_wr_ack), 32'h1);
    end
    i_en = 1'b1;
    repeat (30) @(negedge clk);

    // Reset mid-blink while channel 0 is lit.
    wr(0, 2, 1);
    wr(1, 1, 1);
    for (int i = 0; i < 40 && !o_LED[0]; i++) @(negedge clk);
    check("pre_rst_led0_high", 32'(o_LED[0]), 32'h1);
    #2 resetN = 1'b0;
    #1;
    check("rst_async_led", 32'(o_LED), 32'h0);
    check("rst_async_ack", 32'(o_wr_ack), 32'h0);
    check("rst_async_err", 32'(o_wr_err), 32'h0);
    repeat (2) @(negedge clk);
    default_blink("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
